// File: rtl/lcd_glyph_writer.sv
// lcd_glyph_writer: renders one font glyph to an ST7735 panel.
// It latches one character request, sends the column/row window and RAMWR
// commands, then streams RGB565 pixels row by row from the external font ROM.
// Optional build macro GLYPH_CLIP_EN: a request whose glyph would extend past
// the panel edge writes no bytes, and show_char_done follows 2 cycles after
// the request.
module lcd_glyph_writer #(
  parameter int X_OFFSET = 1,
  parameter int Y_OFFSET = 2,
  parameter int LCD_W    = 160,
  parameter int LCD_H    = 128
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        show_char_flag,
  input  logic [7:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  input  logic [15:0] background_color,
  input  logic [15:0] front_color,
  output logic        font_sel,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [8:0]  spi_data,
  output logic        spi_en,
  input  logic        spi_done,
  output logic        busy,
  output logic        show_char_done
);

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, PIX_HI, PIX_LO, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        issued_q, issued_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  shift_q, shift_d;
  logic [8:0]  sx_q, sx_d, sy_q, sy_d;
  logic [15:0] fg_q, fg_d, bg_q, bg_d;
  logic        clip_q, clip_d;
  logic        font_sel_q, font_sel_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic [8:0]  spi_data_q, spi_data_d;
  logic        spi_en_q, spi_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Window geometry derived from the latched request; font_sel_q is the size.
  logic [15:0] xs, xe, ys, ye;
  logic [2:0]  last_col;
  logic [3:0]  last_row;
  logic [3:0]  setup_idx;
  logic [8:0]  setup_b;
  logic [6:0]  glyph;
  logic [10:0] glyph_base;
  logic        clip;

  assign xs       = {7'd0, sx_q} + 16'(X_OFFSET);
  assign xe       = xs + (font_sel_q ? 16'd7 : 16'd5);
  assign ys       = {7'd0, sy_q} + 16'(Y_OFFSET);
  assign ye       = ys + (font_sel_q ? 16'd15 : 16'd11);
  assign last_col = font_sel_q ? 3'd7 : 3'd5;
  assign last_row = font_sel_q ? 4'd15 : 4'd11;

  // Out-of-range glyph codes fall back to the space glyph.
  assign glyph      = (ascii_num > 8'd94) ? 7'd0 : ascii_num[6:0];
  assign glyph_base = en_size ? {glyph, 4'b0000}
                              : ({1'b0, glyph, 3'b000} + {2'b00, glyph, 2'b00});
  assign clip = ((10'(start_x) + (en_size ? 10'd8 : 10'd6)) > 10'(LCD_W)) ||
                ((10'(start_y) + (en_size ? 10'd16 : 10'd12)) > 10'(LCD_H));

  // Index of the setup byte to issue this cycle: 0 on entry, else the next one.
  assign setup_idx = issued_q ? (cnt_q + 4'd1) : 4'd0;

  // Setup byte table: CASET, RASET with big-endian coordinates, then RAMWR.
  always_comb begin
    setup_b = 9'h000;
    case (setup_idx)
      4'd0:    setup_b = {1'b0, 8'h2A};
      4'd1:    setup_b = {1'b1, xs[15:8]};
      4'd2:    setup_b = {1'b1, xs[7:0]};
      4'd3:    setup_b = {1'b1, xe[15:8]};
      4'd4:    setup_b = {1'b1, xe[7:0]};
      4'd5:    setup_b = {1'b0, 8'h2B};
      4'd6:    setup_b = {1'b1, ys[15:8]};
      4'd7:    setup_b = {1'b1, ys[7:0]};
      4'd8:    setup_b = {1'b1, ye[15:8]};
      4'd9:    setup_b = {1'b1, ye[7:0]};
      default: setup_b = {1'b0, 8'h2C};
    endcase
  end

  // Next-state and output logic. Each byte is issued on the spi_done of the
  // previous one, so only one byte is ever outstanding at the writer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    col_d       = col_q;
    row_d       = row_q;
    shift_d     = shift_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    clip_d      = clip_q;
    font_sel_d  = font_sel_q;
    font_addr_d = font_addr_q;
    spi_data_d  = spi_data_q;
    spi_en_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (show_char_flag && !busy_q) begin
          sx_d        = start_x;
          sy_d        = start_y;
          fg_d        = front_color;
          bg_d        = background_color;
          font_sel_d  = en_size;
          font_addr_d = glyph_base;
          cnt_d       = 4'd0;
          issued_d    = 1'b0;
          col_d       = 3'd0;
          row_d       = 4'd0;
          busy_d      = 1'b1;
          clip_d      = 1'b0;
          state_d     = SETUP;
`ifdef GLYPH_CLIP_EN
          if (clip) begin
            clip_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SETUP: begin
        if (!issued_q) begin
          spi_data_d = setup_b;
          spi_en_d   = 1'b1;
          issued_d   = 1'b1;
        end else if (spi_done) begin
          if (cnt_q == 4'd10) begin
            state_d = FETCH;
          end else begin
            cnt_d      = cnt_q + 4'd1;
            spi_data_d = setup_b;
            spi_en_d   = 1'b1;
          end
        end
      end
      FETCH: begin
        // The ROM address has been stable since the previous row, so the row
        // bits are already valid; capture them and issue the first pixel.
        shift_d    = font_data;
        spi_data_d = {1'b1, font_data[7] ? fg_q[15:8] : bg_q[15:8]};
        spi_en_d   = 1'b1;
        state_d    = PIX_HI;
        if (row_q != last_row) font_addr_d = font_addr_q + 11'd1;
      end
      PIX_HI: begin
        if (spi_done) begin
          spi_data_d = {1'b1, shift_q[7] ? fg_q[7:0] : bg_q[7:0]};
          spi_en_d   = 1'b1;
          state_d    = PIX_LO;
        end
      end
      PIX_LO: begin
        if (spi_done) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (col_q != last_col) begin
            col_d      = col_q + 3'd1;
            spi_data_d = {1'b1, shift_q[6] ? fg_q[15:8] : bg_q[15:8]};
            spi_en_d   = 1'b1;
            state_d    = PIX_HI;
          end else begin
            col_d = 3'd0;
            if (row_q != last_row) begin
              row_d   = row_q + 4'd1;
              state_d = FETCH;
            end else begin
              row_d   = 4'd0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        // A clipped request reaches here straight from IDLE; it signals
        // completion now and lets busy drop one cycle later in IDLE.
        if (clip_q) done_d = 1'b1;
        clip_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any character in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      issued_q    <= 1'b0;
      col_q       <= 3'd0;
      row_q       <= 4'd0;
      shift_q     <= 8'd0;
      sx_q        <= 9'd0;
      sy_q        <= 9'd0;
      fg_q        <= 16'd0;
      bg_q        <= 16'd0;
      clip_q      <= 1'b0;
      font_sel_q  <= 1'b0;
      font_addr_q <= 11'd0;
      spi_data_q  <= 9'd0;
      spi_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      col_q       <= col_d;
      row_q       <= row_d;
      shift_q     <= shift_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      clip_q      <= clip_d;
      font_sel_q  <= font_sel_d;
      font_addr_q <= font_addr_d;
      spi_data_q  <= spi_data_d;
      spi_en_q    <= spi_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign font_sel       = font_sel_q;
  assign font_addr      = font_addr_q;
  assign spi_data       = spi_data_q;
  assign spi_en         = spi_en_q;
  assign busy           = busy_q;
  assign show_char_done = done_q;

endmodule

// File: tb/tb_lcd_glyph_writer.sv
// Scoreboard bench for lcd_glyph_writer: stimulus pushes the expected byte
// stream, a negedge monitor pops and compares every spi_en byte.
module tb_lcd_glyph_writer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        show_char_flag = 1'b0;
  logic [7:0]  ascii_num = 8'd0;
  logic [8:0]  start_x = 9'd0, start_y = 9'd0;
  logic        en_size = 1'b0;
  logic [15:0] background_color = 16'd0, front_color = 16'd0;
  logic        font_sel;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'd0;
  logic [8:0]  spi_data;
  logic        spi_en;
  logic        spi_done;
  logic        busy, show_char_done;

  int tests = 0, fails = 0, cyc = 0;
  int nbytes = 0, ndone = 0, last_sd_cyc = -10;
  bit chk_lat = 1'b1;
  logic [7:0] rom [0:2047];
  logic [8:0] expq [$];
  int wcnt = 0;

  lcd_glyph_writer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .show_char_flag(show_char_flag),
    .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y), .en_size(en_size),
    .background_color(background_color), .front_color(front_color),
    .font_sel(font_sel), .font_addr(font_addr), .font_data(font_data),
    .spi_data(spi_data), .spi_en(spi_en), .spi_done(spi_done), .busy(busy),
    .show_char_done(show_char_done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Font ROM with one cycle of read latency.
  always @(posedge sys_clk) font_data <= rom[font_addr];

  // SPI byte writer: spi_done a few cycles after each spi_en.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wcnt <= 0;
      spi_done <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (spi_en) wcnt <= 3;
      else if (wcnt == 1) begin spi_done <= 1'b1; wcnt <= 0; end
      else if (wcnt > 1) wcnt <= wcnt - 1;
    end
  end

  // Monitor: compare each written byte against the scoreboard queue.
  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (sys_rst_n) begin
      if (spi_done) last_sd_cyc = cyc;
      if (spi_en) begin
        nbytes++;
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL extra_byte got=%h required=none", spi_data);
        end else begin
          e = expq.pop_front();
          if (spi_data !== e) begin
            fails++;
            $display("FAIL byte%0d got=%h required=%h", nbytes - 1, spi_data, e);
          end
        end
      end
      if (show_char_done) begin
        ndone++;
        if (chk_lat) begin
          tests++;
          if (cyc - last_sd_cyc != 1) begin
            fails++;
            $display("FAIL done_latency got=%0d required=1", cyc - last_sd_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk); #2;
  endtask

  // Expected stream: hand-computed window bytes, pixels from the ROM table.
  task automatic push_exp(input logic s, input int base, input logic [15:0] fc, bc,
                          input logic [15:0] xs, xe, ys, ye);
    int w, h;
    logic [7:0] r;
    logic [15:0] c;
    w = s ? 8 : 6;
    h = s ? 16 : 12;
    expq.push_back({1'b0, 8'h2A});
    expq.push_back({1'b1, xs[15:8]}); expq.push_back({1'b1, xs[7:0]});
    expq.push_back({1'b1, xe[15:8]}); expq.push_back({1'b1, xe[7:0]});
    expq.push_back({1'b0, 8'h2B});
    expq.push_back({1'b1, ys[15:8]}); expq.push_back({1'b1, ys[7:0]});
    expq.push_back({1'b1, ye[15:8]}); expq.push_back({1'b1, ye[7:0]});
    expq.push_back({1'b0, 8'h2C});
    for (int i = 0; i < h; i++) begin
      r = rom[base + i];
      for (int j = 0; j < w; j++) begin
        c = r[7 - j] ? fc : bc;
        expq.push_back({1'b1, c[15:8]});
        expq.push_back({1'b1, c[7:0]});
      end
    end
  endtask

  task automatic req(input logic [7:0] a, input logic [8:0] x, y, input logic s,
                     input logic [15:0] fc, bc);
    tick;
    show_char_flag = 1'b1; ascii_num = a; start_x = x; start_y = y;
    en_size = s; front_color = fc; background_color = bc;
    tick;
    show_char_flag = 1'b0;
  endtask

  task automatic wait_bytes(input string nm, input int n);
    int k = 0;
    while (nbytes < n && k < 5000) begin tick; k++; end
    if (k >= 5000) chk({nm, "_wait_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input string nm, input int exp_bytes);
    int k = 0;
    while (show_char_done !== 1'b1 && k < 5000) begin tick; k++; end
    chk({nm, "_done_seen"}, int'(k < 5000), 1);
    repeat (3) tick;
    chk({nm, "_bytes"}, nbytes, exp_bytes);
    chk({nm, "_done_count"}, ndone, 1);
    chk({nm, "_queue_left"}, expq.size(), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
    nbytes = 0; ndone = 0; expq.delete();
  endtask

  // Full character: request, busy/latency/address checks, completion.
  task automatic run(input string nm, input logic [7:0] a, input logic [8:0] x, y,
                     input logic s, input logic [15:0] fc, bc, input int base,
                     input logic [15:0] xs, xe, ys, ye);
    push_exp(s, base, fc, bc, xs, xe, ys, ye);
    req(a, x, y, s, fc, bc);
    chk({nm, "_busy"}, int'(busy), 1);
    chk({nm, "_spi_en_early"}, int'(spi_en), 0);
    chk({nm, "_addr_first"}, int'(font_addr), base);
    chk({nm, "_font_sel"}, int'(font_sel), int'(s));
    tick;
    chk({nm, "_first_spi_en"}, int'(spi_en), 1);
    wait_done(nm, s ? 267 : 155);
    chk({nm, "_addr_last"}, int'(font_addr), base + (s ? 15 : 11));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    rom[688] = 8'h80;                                       // glyph 43 row 0
    for (int r = 0; r < 12; r++) rom[204 + r] = r[0] ? 8'h57 : 8'hAB; // glyph 17
    for (int r = 0; r < 16; r++) rom[r] = 8'(1 << (r % 8)); // glyph 0

    repeat (3) tick;
    chk("reset_outputs", int'({font_sel, font_addr, spi_data, spi_en, busy, show_char_done}), 0);
    sys_rst_n = 1'b1;
    repeat (2) tick;

    run("k16x8", 8'd43, 9'd48, 9'd0, 1'b1, 16'hFFFF, 16'hAF7D, 688,
        16'h0031, 16'h0038, 16'h0002, 16'h0011);

    run("g12x6", 8'd17, 9'd1, 9'd32, 1'b0, 16'hF800, 16'h001F, 204,
        16'h0002, 16'h0007, 16'h0022, 16'h002D);

    // Second request mid-transfer is dropped.
    push_exp(1'b1, 688, 16'hFFFF, 16'hAF7D, 16'h0031, 16'h0038, 16'h0002, 16'h0011);
    req(8'd43, 9'd48, 9'd0, 1'b1, 16'hFFFF, 16'hAF7D);
    wait_bytes("repulse", 50);
    req(8'd5, 9'd10, 9'd10, 1'b0, 16'h1234, 16'h5678);
    wait_done("repulse", 267);

    // Reset during pixel 20 aborts with no completion.
    push_exp(1'b0, 204, 16'hF800, 16'h001F, 16'h0002, 16'h0007, 16'h0022, 16'h002D);
    req(8'd17, 9'd1, 9'd32, 1'b0, 16'hF800, 16'h001F);
    wait_bytes("abort", 31);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_outputs", int'({font_sel, font_addr, spi_data, spi_en, busy, show_char_done}), 0);
    expq.delete();
    repeat (2) tick;
    chk("abort_no_done", ndone, 0);
    sys_rst_n = 1'b1;
    nbytes = 0; ndone = 0;
    tick;
    run("after_rst", 8'd43, 9'd48, 9'd0, 1'b1, 16'hFFFF, 16'hAF7D, 688,
        16'h0031, 16'h0038, 16'h0002, 16'h0011);

    run("ascii120", 8'd120, 9'd0, 9'd0, 1'b1, 16'h07E0, 16'h0000, 0,
        16'h0001, 16'h0008, 16'h0002, 16'h0011);

`ifdef GLYPH_CLIP_EN
    chk_lat = 1'b0;
    req(8'd43, 9'd156, 9'd0, 1'b1, 16'hFFFF, 16'hAF7D);
    chk("clip_busy1", int'(busy), 1);
    chk("clip_done_early", int'(show_char_done), 0);
    tick;
    chk("clip_done", int'(show_char_done), 1);
    chk("clip_busy2", int'(busy), 1);
    tick;
    chk("clip_done_off", int'(show_char_done), 0);
    chk("clip_busy_off", int'(busy), 0);
    repeat (3) tick;
    chk("clip_bytes", nbytes, 0);
    chk("clip_done_count", ndone, 1);
    nbytes = 0; ndone = 0;
    chk_lat = 1'b1;
`else
    run("edge_x156", 8'd43, 9'd156, 9'd0, 1'b1, 16'hFFFF, 16'hAF7D, 688,
        16'h009D, 16'h00A4, 16'h0002, 16'h0011);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_glyph_writer.md
Name: lcd_glyph_writer

Overview:
- Render stage directly downstream of the mode display blocks (keyboard/menu show).
- Takes one character request (show_char_flag, ascii_num, start_x, start_y, en_size, colours) and reads the glyph from the external font ROM.
- Emits the ST7735 window-set, RAMWR and pixel byte stream to the SPI byte writer, then pulses show_char_done so the upstream block advances to its next character.

Parameters:
- X_OFFSET, 1, panel column address offset added to start_x
- Y_OFFSET, 2, panel row address offset added to start_y
- LCD_W, 160, visible width in pixels (landscape)
- LCD_H, 128, visible height in pixels

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  async active-low reset
- show_char_flag  in  1  one-cycle request strobe
- ascii_num  in  8  glyph index (ASCII-32), valid 0..94
- start_x  in  9  top-left x in pixels
- start_y  in  9  top-left y in pixels
- en_size  in  1  1 = 16x8 font, 0 = 12x6 font
- background_color  in  16  RGB565 for glyph bit 0
- front_color  in  16  RGB565 for glyph bit 1
- font_sel  out  1  ROM bank select (mirrors latched en_size)
- font_addr  out  11  ROM address = glyph*rows + row
- font_data  in  8  ROM row bits, MSB = leftmost column; 1-cycle read latency; 12x6 rows MSB-aligned in bits 7:2
- spi_data  out  9  bit8 = D/C (0 cmd, 1 data), bits7:0 = byte
- spi_en  out  1  one-cycle byte write strobe
- spi_done  in  1  one-cycle pulse when the byte writer finishes a byte
- busy  out  1  high from accepted request until show_char_done
- show_char_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately. No show_char_done is produced for the aborted character.
- IDLE:
  - On show_char_flag, latch all request inputs and set busy the next cycle.
  - ascii_num > 94 is latched as 0 (space).
  - show_char_flag while busy is ignored. It is not queued.
- Geometry:
  - W,H = 8,16 if en_size, else 6,12.
  - xs = start_x + X_OFFSET, xe = xs + W - 1, ys = start_y + Y_OFFSET, ye = ys + H - 1.
  - All computed 16-bit, zero-extended.
- Byte sequence (11 setup bytes, then H*W*2 pixel bytes):
  - 0x2A(cmd), xs[15:8], xs[7:0], xe[15:8], xe[7:0]
  - 0x2B(cmd), ys[15:8], ys[7:0], ye[15:8], ye[7:0]
  - 0x2C(cmd)
  - Pixels row-major, left to right. For each pixel: colour[15:8], then colour[7:0].
- Handshake:
  - The first spi_en is asserted exactly 1 cycle after busy rises.
  - Each subsequent spi_en comes 1 cycle after the spi_done of the previous byte.
  - The FETCH cycle at each row start adds 1 extra cycle. Never more than one byte is outstanding.
- States: IDLE, SETUP (cnt 0..10), FETCH (drive font_addr, wait 1 cycle, capture font_data into row shift register), PIX_HI, PIX_LO, DONE.
  - SETUP moves to FETCH after the spi_done for byte 10.
  - PIX_LO spi_done:
    - next column → PIX_HI
    - last column, more rows → FETCH
    - last row → DONE
  - DONE pulses show_char_done for 1 cycle, clears busy, and returns to IDLE.
- Counters:
  - col is 3-bit, row is 4-bit, both wrap to 0 per character.
  - font_addr = glyph*16 + row for 16x8, glyph*12 + row for 12x6.
- Colour pick: bit = shift register MSB; 1 → front_color, 0 → background_color. Shift left after each PIX_LO.
- Stray spi_done while IDLE or FETCH is ignored.

Optional Feature:
- Macro: GLYPH_CLIP_EN.
- Defined:
  - Latch-time check: if start_x + W > LCD_W or start_y + H > LCD_H, no bytes are written.
  - show_char_done pulses 2 cycles after the request. busy stays high for those 2 cycles.
- Undefined: no check; the window is sent as computed.

Test Plan:
- 16x8, ascii_num=43 ('K'), start (48,0), font_data row0=0x80, rest 0, front=0xFFFF, bg=0xAF7D:
  - Setup bytes are 0x2A,00,31,00,38,0x2B,00,02,00,11,0x2C with D/C = 0,1,1,1,1,0,1,1,1,1,0.
  - 256 pixel bytes follow, starting FF,FF, then 7×(AF,7D).
  - 267 writes total; show_char_done 1 cycle after the last spi_done.
- 12x6, ascii_num=17, start (1,32):
  - xe=0x0007, ye=0x002D.
  - font_addr runs 204..215.
  - 155 writes total; each row emits exactly 6 pixels.
- show_char_flag re-pulsed mid-transfer with different ascii_num: ignored; byte stream unchanged; exactly one show_char_done.
- sys_rst_n low during pixel 20: all outputs 0 next edge. A new request after release starts a clean 0x2A sequence.
- ascii_num=120: glyph 0 used (font_addr 0..15).
- start_x=156, en_size=1:
  - With GLYPH_CLIP_EN: zero spi_en, show_char_done 2 cycles after the flag.
  - Without: full 267-byte stream.
